// File: rtl/clk_rst_ctl.sv
// Clock-enable strobe generator and stretched reset sequencer for the single-clock system.
// Optional channel-0 single-step gate is compiled in when CLKRST_STEP_EN is defined.
module clk_rst_ctl #(
    parameter int          CHANNELS   = 2,
    parameter int          DIV_W      = 16,
    parameter int unsigned DIV_INIT   = 2047,
    parameter int          RST_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_sel,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                step_mode,
    input  logic                step_req,
    output logic [CHANNELS-1:0] ce,
    output logic                rst_out,
    output logic                halted
);

    localparam int RST_W = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;
    localparam logic [RST_W-1:0] RST_CNT_INIT = RST_W'(RST_CYCLES);
    localparam logic [DIV_W-1:0] DIV_RESET    = DIV_W'(DIV_INIT);

    typedef enum logic {
        SEQ_HOLD = 1'b0,
        SEQ_RUN  = 1'b1
    } seq_state_e;

    logic [DIV_W-1:0]    cnt_q [CHANNELS];
    logic [DIV_W-1:0]    cnt_d [CHANNELS];
    logic [DIV_W-1:0]    div_q [CHANNELS];
    logic [DIV_W-1:0]    div_d [CHANNELS];
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] raw_tick;
    logic [CHANNELS-1:0] ce_q;
    logic [CHANNELS-1:0] ce_d;
    logic                tick0;

    seq_state_e          seq_q;
    seq_state_e          seq_d;
    logic [RST_W-1:0]    rst_cnt_q;
    logic [RST_W-1:0]    rst_cnt_d;
    logic                in_reset;

    // Out-of-range selects match no channel, so such writes fall through untouched.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_sel[i] = cfg_we && (cfg_sel == 4'(i));
        end
    end

    // A divisor write restarts the channel and swallows any tick of that same cycle.
    always_comb begin
        raw_tick = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            div_d[i] = div_q[i];
            if (wr_sel[i]) begin
                div_d[i] = cfg_div;
                cnt_d[i] = '0;
            end else if (cnt_q[i] == div_q[i]) begin
                raw_tick[i] = 1'b1;
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_RESET;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
        end
    end

    assign in_reset = (seq_q == SEQ_HOLD);

`ifdef CLKRST_STEP_EN
    logic armed_q;
    logic armed_d;
    logic halted_q;
    logic halted_d;
    logic gate_on;

    // A request raised in the tick cycle itself only arms for the following tick.
    always_comb begin
        gate_on  = step_mode && !in_reset;
        armed_d  = step_req | (armed_q & ~raw_tick[0]);
        tick0    = gate_on ? (raw_tick[0] & armed_q) : raw_tick[0];
        halted_d = step_mode & ~armed_q & ~in_reset;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            armed_q  <= armed_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`else
    logic unused_step;

    assign unused_step = step_mode ^ step_req;
    assign tick0       = raw_tick[0];
    assign halted      = 1'b0;
`endif

    always_comb begin
        ce_d    = raw_tick;
        ce_d[0] = tick0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q <= '0;
        end else begin
            ce_q <= ce_d;
        end
    end

    // Counts the registered channel-0 strobes so downstream sees RST_CYCLES+1 of them in reset.
    always_comb begin
        seq_d     = seq_q;
        rst_cnt_d = rst_cnt_q;
        case (seq_q)
            SEQ_HOLD: begin
                if (ce_q[0]) begin
                    if (rst_cnt_q != '0) begin
                        rst_cnt_d = rst_cnt_q - RST_W'(1);
                    end else begin
                        seq_d = SEQ_RUN;
                    end
                end
            end
            SEQ_RUN: begin
                seq_d = SEQ_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_q     <= SEQ_HOLD;
            rst_cnt_q <= RST_CNT_INIT;
        end else begin
            seq_q     <= seq_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    assign ce      = ce_q;
    assign rst_out = in_reset;

endmodule

// File: tb/tb_clk_rst_ctl.sv
// Directed bench for clk_rst_ctl with DIV_INIT=3, RST_CYCLES=3, two channels.
// Step-gate scenarios follow CLKRST_STEP_EN; without it the step inputs must be ignored.
module tb_clk_rst_ctl;

    localparam int CHANNELS   = 2;
    localparam int DIV_W      = 16;
    localparam int DIV_INIT   = 3;
    localparam int RST_CYCLES = 3;
    localparam int PER        = DIV_INIT + 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_we = 1'b0;
    logic [3:0]          cfg_sel = 4'd0;
    logic [DIV_W-1:0]    cfg_div = '0;
    logic                step_mode = 1'b0;
    logic                step_req = 1'b0;
    logic [CHANNELS-1:0] ce;
    logic                rst_out;
    logic                halted;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int t0           = 0;

    clk_rst_ctl #(
        .CHANNELS  (CHANNELS),
        .DIV_W     (DIV_W),
        .DIV_INIT  (DIV_INIT),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_div  (cfg_div),
        .step_mode(step_mode),
        .step_req (step_req),
        .ce       (ce),
        .rst_out  (rst_out),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Checks a full reset-release sequence; 'step' holds step_mode high throughout.
    task automatic run_reset_sequence(input string tag, input logic step);
        logic [1:0] exp_ce;
        logic       exp_rst;
        logic       exp_halt;
        step_mode = step;
        step_req  = 1'b0;
        cfg_we    = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        t0  = cyc;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            exp_ce   = (k > 0 && (k % PER) == 0) ? 2'b11 : 2'b00;
            exp_rst  = (k <= 16);
            exp_halt = 1'b0;
`ifdef CLKRST_STEP_EN
            if (step && k >= 18) exp_halt = 1'b1;
            if (step && k == 20) exp_ce[0] = 1'b0;
`endif
            tests_run++;
            if (ce !== exp_ce) begin
                tests_failed++;
                $display("FAIL %s k=%0d ce: got %b want %b", tag, k, ce, exp_ce);
            end
            tests_run++;
            if (rst_out !== exp_rst) begin
                tests_failed++;
                $display("FAIL %s k=%0d rst_out: got %b want %b", tag, k, rst_out, exp_rst);
            end
            tests_run++;
            if (halted !== exp_halt) begin
                tests_failed++;
                $display("FAIL %s k=%0d halted: got %b want %b", tag, k, halted, exp_halt);
            end
        end
    endtask

    task automatic test_reset();
        run_reset_sequence("reset", 1'b0);
    endtask

    task automatic test_cfg_write();
        logic exp0;
        logic exp1;
        // Align so the old cadence would tick in the very cycle of the write.
        while (((cyc - t0) % PER) != PER - 1) tick();
        cfg_we  = 1'b1;
        cfg_sel = 4'd1;
        cfg_div = 16'd5;
        for (int j = 1; j <= 14; j++) begin
            tick();
            cfg_we = 1'b0;
            exp1 = (j == 7) || (j == 13);
            exp0 = ((cyc - t0) % PER) == 0;
            tests_run++;
            if (ce[1] !== exp1) begin
                tests_failed++;
                $display("FAIL cfg_write j=%0d ce1: got %b want %b", j, ce[1], exp1);
            end
            tests_run++;
            if (ce[0] !== exp0) begin
                tests_failed++;
                $display("FAIL cfg_write j=%0d ce0: got %b want %b", j, ce[0], exp0);
            end
        end
    endtask

    task automatic test_div_zero();
        logic exp0;
        logic exp1;
        cfg_we  = 1'b1;
        cfg_sel = 4'd1;
        cfg_div = 16'd0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            cfg_we = 1'b0;
            exp1 = (j >= 2);
            exp0 = ((cyc - t0) % PER) == 0;
            tests_run++;
            if (ce[1] !== exp1) begin
                tests_failed++;
                $display("FAIL div_zero j=%0d ce1: got %b want %b", j, ce[1], exp1);
            end
            tests_run++;
            if (ce[0] !== exp0) begin
                tests_failed++;
                $display("FAIL div_zero j=%0d ce0: got %b want %b", j, ce[0], exp0);
            end
        end
    endtask

    task automatic test_invalid_sel();
        logic [3:0] sels [2];
        logic       exp0;
        sels[0] = 4'd15;
        sels[1] = 4'd2;
        for (int s = 0; s < 2; s++) begin
            cfg_we  = 1'b1;
            cfg_sel = sels[s];
            cfg_div = 16'd9;
            for (int j = 1; j <= 6; j++) begin
                tick();
                cfg_we = 1'b0;
                exp0 = ((cyc - t0) % PER) == 0;
                tests_run++;
                if (ce[1] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL invalid_sel sel=%0d j=%0d ce1: got %b want 1", sels[s], j, ce[1]);
                end
                tests_run++;
                if (ce[0] !== exp0) begin
                    tests_failed++;
                    $display("FAIL invalid_sel sel=%0d j=%0d ce0: got %b want %b", sels[s], j, ce[0], exp0);
                end
            end
        end
    endtask

`ifdef CLKRST_STEP_EN
    task automatic test_step();
        logic [1:0] exp_ce;
        logic       exp_halt;
        step_mode = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            tests_run++;
            if (ce !== 2'b10) begin
                tests_failed++;
                $display("FAIL step_hold j=%0d ce: got %b want 10", j, ce);
            end
            tests_run++;
            if (halted !== 1'b1) begin
                tests_failed++;
                $display("FAIL step_hold j=%0d halted: got %b want 1", j, halted);
            end
        end
        // Request coincides with a raw tick, which must not pass; the next one does.
        while (((cyc - t0) % PER) != PER - 1) tick();
        step_req = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            step_req = 1'b0;
            exp_ce   = (j == 5) ? 2'b11 : 2'b10;
            exp_halt = !(j >= 2 && j <= 5);
            tests_run++;
            if (ce !== exp_ce) begin
                tests_failed++;
                $display("FAIL step_one j=%0d ce: got %b want %b", j, ce, exp_ce);
            end
            tests_run++;
            if (halted !== exp_halt) begin
                tests_failed++;
                $display("FAIL step_one j=%0d halted: got %b want %b", j, halted, exp_halt);
            end
        end
    endtask
`else
    task automatic test_step();
        logic exp0;
        step_mode = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            step_req = (j % 2) == 1;
            tick();
            exp0 = ((cyc - t0) % PER) == 0;
            tests_run++;
            if (ce[0] !== exp0) begin
                tests_failed++;
                $display("FAIL step_ignored j=%0d ce0: got %b want %b", j, ce[0], exp0);
            end
            tests_run++;
            if (halted !== 1'b0) begin
                tests_failed++;
                $display("FAIL step_ignored j=%0d halted: got %b want 0", j, halted);
            end
        end
        step_req = 1'b0;
    endtask
`endif

    task automatic test_step_during_reset();
        run_reset_sequence("step_rst", 1'b1);
    endtask

    task automatic test_mid_run_reset();
        cfg_we  = 1'b1;
        cfg_sel = 4'd1;
        cfg_div = 16'd6;
        tick();
        cfg_we   = 1'b0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        run_reset_sequence("mid_rst", 1'b1);
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_div_zero();
        test_invalid_sel();
        test_step();
        test_step_during_reset();
        test_mid_run_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clk_rst_ctl.md
# clk_rst_ctl

Parametrised clock-enable and reset sequencer for the single-clock system: generates `CHANNELS` independent, runtime-programmable clock-enable strobes from the board clock and a stretched system reset counted on channel 0. It supersedes the fixed counter-bit CPU clock and the hard-wired startup reset hold. Downstream logic (cpu, sdram, serialout, vga) runs on the board clock and qualifies its registers with `ce[i]`. An optional single-step gate on channel 0 supports debug stepping of the CPU.

## Interface
Parameters:
- `CHANNELS`, 2: number of enable channels, 1..16.
- `DIV_W`, 16: divisor and counter width.
- `DIV_INIT`, 2047: divisor loaded at reset for every channel; period is `DIV_INIT+1` cycles.
- `RST_CYCLES`, 3: number of extra channel-0 strobes for which `rst_out` is held after `rst` drops.

Ports:
- `clk` in 1: board clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_we` in 1: divisor write strobe.
- `cfg_sel` in 4: channel index for the write.
- `cfg_div` in `DIV_W`: new divisor.
- `step_mode` in 1: channel-0 single-step enable.
- `step_req` in 1: request one channel-0 strobe while stepping.
- `ce` out `CHANNELS`: registered one-cycle enable strobes.
- `rst_out` out 1: system reset for downstream blocks.
- `halted` out 1: channel 0 held by the step gate.

## Operation
- Per channel: counter `cnt[i]` (`DIV_W` bits) and divisor `div[i]`.
  - On reset: `cnt`=0, `div`=`DIV_INIT`.
  - Each cycle: if `cnt==div`, then raw tick, `cnt`<=0; else `cnt`<=`cnt`+1.
  - `ce[i]` is the registered raw tick (after step gating for channel 0).
- `div`=0: `ce[i]` is continuously 1 (period 1).
- Config write (`cfg_we`=1, `cfg_sel`<`CHANNELS`):
  - `div[sel]`<=`cfg_div`, `cnt[sel]`<=0.
  - A raw tick coinciding with the write is suppressed.
  - The next strobe comes `cfg_div+1` cycles later.
- `cfg_sel`>=`CHANNELS`: the write is ignored.
- Reset sequencer:
  - Reset values: `rst_out`=1, `rst_cnt`=`RST_CYCLES`.
  - On each cycle with `ce[0]`=1 and `rst_out`=1: if `rst_cnt`!=0, decrement; else `rst_out`<=0.
  - Downstream logic therefore sees exactly `RST_CYCLES+1` channel-0 strobes with `rst_out`=1.
  - `rst_out` never reasserts except via `rst`.
- Step gate: active only when `step_mode`=1 and `rst_out`=0.
  - `armed` <= `step_req` | (`armed` & ~raw_tick0).
  - Gated tick0 = raw_tick0 & `armed`; `step_req` arriving in the same cycle as a tick does not pass that tick.
  - When armed with a coincident tick and `step_req`, one strobe is emitted and `armed` stays set.
- `halted` = `step_mode` & ~`armed` & ~`rst_out`, registered.
- Channels >=1 are never gated.
- `rst` asserted mid-operation: all state returns to reset values next edge; runtime divisors are lost; a pending `armed` is cleared.

## Timing
- Output reset values: `ce`=0, `rst_out`=1, `halted`=0.
- Strobe latency is one cycle after the raw tick. Strobe k (k>=1) after reset release at cycle t0 appears at t0+D+1+(k-1)(D+1), where D is the divisor.
- `rst_out` falls in the cycle after the (`RST_CYCLES+1`)-th `ce[0]` pulse.
- Config write at cycle t: first new strobe at t+`cfg_div`+2.
- `step_req` at cycle t: `ce[0]` on the first raw tick at >=t+1, output one cycle later.

## Configuration
- `CLKRST_STEP_EN`
  - Defined: step gate and `halted` are implemented as above.
  - Undefined: `step_mode` and `step_req` are ignored, `halted` is tied 0, channel 0 free-runs, and no `armed` register exists.

## Test plan
- Reset release with `DIV_INIT`=3, `RST_CYCLES`=3: `ce[0]` pulses at t0+4, 8, 12, 16; `rst_out` is 1 through t0+16 and 0 from t0+17.
- Write `cfg_sel`=1, `cfg_div`=5 at cycle t: no `ce[1]` pulse at the old cadence; pulses at t+7 and t+13.
- `cfg_div`=0 on channel 1: `ce[1]` is high every cycle from t+2. Writing `cfg_sel`=15 with `CHANNELS`=2 changes nothing.
- `CLKRST_STEP_EN` defined, `step_mode`=1 after reset done, D=3:
  - `halted`=1 and no `ce[0]`.
  - One-cycle `step_req`: exactly one `ce[0]` at the next tick, then `halted`=1 again.
  - `ce[1]` is unaffected throughout.
- `step_mode`=1 during `rst_out`=1: `ce[0]` free-runs and `rst_out` releases on the normal schedule.
- Assert `rst` for one cycle mid-run after divisor writes:
  - Next cycle: `ce`=0, `rst_out`=1, divisors are back to `DIV_INIT`.
  - The full reset sequence repeats.
